// File: rtl/match_table_ctrl_if.sv
// Programming bus for one match-table instance: two write requesters in,
// one unpacked table write port out.
interface match_table_ctrl_if #(
  parameter int KEY_WIDTH         = 32,
  parameter int TABLE_SIZE        = 1024,
  parameter int ACTION_DATA_WIDTH = 128
);
  localparam int AW = $clog2(TABLE_SIZE);
  localparam int EW = 1 + 2*KEY_WIDTH + 6 + 3 + ACTION_DATA_WIDTH;

  logic                         req0_valid;
  logic                         req0_ready;
  logic [AW-1:0]                req0_addr;
  logic [EW-1:0]                req0_entry;
  logic                         req1_valid;
  logic                         req1_ready;
  logic [AW-1:0]                req1_addr;
  logic [EW-1:0]                req1_entry;

  logic                         table_write_enable;
  logic [AW-1:0]                table_write_addr;
  logic                         table_entry_valid;
  logic [KEY_WIDTH-1:0]         table_entry_key;
  logic [KEY_WIDTH-1:0]         table_entry_mask;
  logic [5:0]                   table_entry_prefix_len;
  logic [2:0]                   table_entry_action_id;
  logic [ACTION_DATA_WIDTH-1:0] table_entry_action_data;

  modport master (
    output req0_valid, req0_addr, req0_entry,
    output req1_valid, req1_addr, req1_entry,
    input  req0_ready, req1_ready,
    input  table_write_enable, table_write_addr, table_entry_valid,
    input  table_entry_key, table_entry_mask, table_entry_prefix_len,
    input  table_entry_action_id, table_entry_action_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_entry,
    input  req1_valid, req1_addr, req1_entry,
    output req0_ready, req1_ready,
    output table_write_enable, table_write_addr, table_entry_valid,
    output table_entry_key, table_entry_mask, table_entry_prefix_len,
    output table_entry_action_id, table_entry_action_data
  );
endinterface

// File: rtl/match_table_ctrl.sv
// Write-side controller for a match table: round-robin host/learn write
// arbitration plus a flush sequencer that invalidates every entry.
module match_table_ctrl #(
  parameter int KEY_WIDTH         = 32,
  parameter int TABLE_SIZE        = 1024,
  parameter int ACTION_DATA_WIDTH = 128
) (
  input  logic                aclk,
  input  logic                areset,
  match_table_ctrl_if.slave   bus,
  input  logic                flush_start,
  output logic                flush_busy,
  output logic                flush_done,
  output logic                lookup_hold,
  output logic [15:0]         wr_count0,
  output logic [15:0]         wr_count1
);
  localparam int AW  = $clog2(TABLE_SIZE);
  localparam int EW  = 1 + 2*KEY_WIDTH + 6 + 3 + ACTION_DATA_WIDTH;
  localparam int ADW = ACTION_DATA_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(TABLE_SIZE - 1);
  localparam logic [2:0]    ACT_DROP  = 3'd1;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t            state;
  logic              rr_ptr;
  logic [AW-1:0]     flush_addr;

  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic              valid_q;
  logic [KEY_WIDTH-1:0] key_q, mask_q;
  logic [5:0]        plen_q;
  logic [2:0]        aid_q;
  logic [ADW-1:0]    data_q;

  logic              grant0, grant1, acc0, acc1;
  logic [AW-1:0]     sel_addr;
  logic [EW-1:0]     sel_entry;

  // Ready is gated by the requester's own valid so the pointer only
  // decides contention; a pending flush_start blocks both requesters.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !flush_start) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
      grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign acc0      = grant0 && bus.req0_valid;
  assign acc1      = grant1 && bus.req1_valid;
  assign sel_addr  = acc1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_entry = acc1 ? bus.req1_entry : bus.req0_entry;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      flush_addr  <= '0;
      flush_busy  <= 1'b0;
      flush_done  <= 1'b0;
      lookup_hold <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      key_q       <= '0;
      mask_q      <= '0;
      plen_q      <= '0;
      aid_q       <= '0;
      data_q      <= '0;
      wr_count0   <= '0;
      wr_count1   <= '0;
    end else begin
      we_q       <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_start) begin
            // First invalidate write goes out the very next cycle.
            state       <= FLUSH;
            flush_addr  <= '0;
            flush_busy  <= 1'b1;
            lookup_hold <= 1'b1;
            we_q        <= 1'b1;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            key_q       <= '0;
            mask_q      <= '0;
            plen_q      <= '0;
            aid_q       <= ACT_DROP;
            data_q      <= '0;
          end else if (acc0 || acc1) begin
            we_q    <= 1'b1;
            addr_q  <= sel_addr;
            valid_q <= sel_entry[EW-1];
            key_q   <= sel_entry[EW-2 -: KEY_WIDTH];
            mask_q  <= sel_entry[EW-2-KEY_WIDTH -: KEY_WIDTH];
            plen_q  <= sel_entry[ADW+3 +: 6];
            aid_q   <= sel_entry[ADW +: 3];
            data_q  <= sel_entry[ADW-1:0];
            rr_ptr  <= acc0;
          end
        end
        FLUSH: begin
          // flush_addr mirrors the address currently on the write port.
          if (flush_addr == LAST_ADDR) begin
            state       <= DONE;
            flush_busy  <= 1'b0;
            lookup_hold <= 1'b0;
            flush_done  <= 1'b1;
          end else begin
            flush_addr <= flush_addr + 1'b1;
            addr_q     <= flush_addr + 1'b1;
            we_q       <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (acc0 && wr_count0 != 16'hFFFF) wr_count0 <= wr_count0 + 16'd1;
      if (acc1 && wr_count1 != 16'hFFFF) wr_count1 <= wr_count1 + 16'd1;
    end
  end

  assign bus.table_write_enable      = we_q;
  assign bus.table_write_addr        = addr_q;
  assign bus.table_entry_valid       = valid_q;
  assign bus.table_entry_key         = key_q;
  assign bus.table_entry_mask        = mask_q;
  assign bus.table_entry_prefix_len  = plen_q;
  assign bus.table_entry_action_id   = aid_q;
  assign bus.table_entry_action_data = data_q;
endmodule

// File: doc/match_table_ctrl.md
Name: match_table_ctrl

Overview:
- Write-side controller for one match-table instance. It shares the single table programming port between two requesters: host control plane (requester 0) and learning/aging engine (requester 1). Round-robin arbitration is used.
- Provides a hardware flush sequencer that invalidates every table entry.
- Asserts a lookup hold so the upstream parser stalls lookups during a flush.
- Sits between control/learn logic and the table write port of the match engine.

Parameters:
- KEY_WIDTH, 32, width of key and mask fields.
- TABLE_SIZE, 1024, number of table entries; address width AW = $clog2(TABLE_SIZE).
- ACTION_DATA_WIDTH, 128, width of action data field.
- Derived localparam EW = 1 + 2*KEY_WIDTH + 6 + 3 + ACTION_DATA_WIDTH.
  - Entry bus packing, MSB to LSB: valid, key, mask, prefix_len[5:0], action_id[2:0], action_data.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  host write request.
- req0_ready  out  1  host request accepted when valid & ready.
- req0_addr  in  AW  host target entry.
- req0_entry  in  EW  host packed entry.
- req1_valid  in  1  learn write request.
- req1_ready  out  1  learn request accepted when valid & ready.
- req1_addr  in  AW  learn target entry.
- req1_entry  in  EW  learn packed entry.
- flush_start  in  1  single-cycle flush request.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse at flush completion.
- lookup_hold  out  1  upstream must not issue lookups.
- table_write_enable  out  1  table write strobe.
- table_write_addr  out  AW  table write address.
- table_entry_valid  out  1  entry valid field.
- table_entry_key  out  KEY_WIDTH  entry key.
- table_entry_mask  out  KEY_WIDTH  entry mask.
- table_entry_prefix_len  out  6  entry prefix length.
- table_entry_action_id  out  3  entry action id.
- table_entry_action_data  out  ACTION_DATA_WIDTH  entry action data.
- wr_count0  out  16  saturating count of accepted host writes.
- wr_count1  out  16  saturating count of accepted learn writes.

Behaviour:
- All outputs are registered except req0_ready and req1_ready, which are combinational from state, valids and the round-robin pointer.
- Reset (async, active-high):
  - State IDLE; all table_* outputs 0.
  - flush_busy = 0, flush_done = 0, lookup_hold = 0.
  - Flush address counter = 0; wr_count0 = wr_count1 = 0.
  - Round-robin pointer = 0, so requester 0 is favoured first.
- States: IDLE, FLUSH, DONE.
- IDLE arbitration:
  - If flush_start=1: no ready asserted that cycle; go to FLUSH; flush counter = 0.
  - Otherwise, if only one valid is high, that requester gets ready.
  - If both are valid, the requester indicated by the pointer gets ready and the other does not.
  - On an accept, the pointer moves to the other requester.
  - Sustained throughput is one write per cycle.
- Write latency:
  - A request accepted in cycle N drives table_write_enable=1 in cycle N+1 for exactly one cycle.
  - In that cycle, addr and fields are the unpacked entry.
  - With no accept in cycle N, write_enable=0 in N+1; data outputs hold their previous value.
- FLUSH:
  - flush_busy=1 and lookup_hold=1 from the cycle after flush_start.
  - Each cycle drives write_enable=1, addr = counter, valid=0, key/mask/prefix_len/action_data=0, action_id=1 (drop); the counter then increments.
  - Exactly TABLE_SIZE consecutive write cycles, addresses 0..TABLE_SIZE-1, with no wrap.
  - After the write to TABLE_SIZE-1, go to DONE.
  - Both ready outputs = 0 throughout FLUSH and DONE.
  - flush_start during FLUSH or DONE is ignored; no restart.
- DONE: one cycle with flush_done=1, flush_busy=0, lookup_hold=0, write_enable=0; then IDLE.
- Counters: increment on accept, saturate at 16'hFFFF, and do not wrap.
- Reset mid-flush: aborts immediately, with no flush_done. Table contents are partially cleared; the host must reissue the flush.
- A request held valid across a flush is accepted normally after return to IDLE; request payloads must stay stable while valid & !ready.

Test Plan:
- TABLE_SIZE=8. Single req0: addr=3, valid=1, key=0x0A000001, action_id=2, accepted cycle N → write_enable in N+1 only with addr=3, key=0x0A000001, action_id=2; wr_count0=1.
- Both valid for 4 cycles: addrs 1 and 5, pointer=0 → write order addr 1, 5, 1, 5; ready alternates; wr_count0=wr_count1=2.
- flush_start with TABLE_SIZE=8 → 8 consecutive writes addr 0..7, valid=0, action_id=1, lookup_hold high throughout; flush_done pulses once in the following cycle; readies 0 throughout.
- flush_start in the same cycle as req1_valid → req1 not accepted; flush runs; req1 accepted on the first IDLE cycle afterward.
- areset asserted at flush write 3 → outputs zero asynchronously, no flush_done; a new flush_start starts again at addr 0.
- Preload wr_count0=0xFFFE via 2 forced accepts on a short-counter build, or run 65537 accepts → count stays 0xFFFF.
